// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
// Module   : render_pkg
// Purpose  : Shared angle type, default angle constants and sequencer states.
// Revision : 1.0
// ============================================================================
package render_pkg;

    typedef logic [11:0] angle_t;  // unsigned 4.8 fixed point

    localparam angle_t ANGLE_STEP_DEF = 12'h01a;
    localparam angle_t ANGLE_MAX_DEF  = 12'h648;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRIG  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DRAW  = 3'd4
    } seq_state_t;

    // Vertex index width, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/render_sequencer_angle_accum.sv
`default_nettype none
// ============================================================================
// Module   : angle_accum
// Purpose  : Rotation angle register; steps by ANGLE_STEP and wraps to zero.
// Revision : 1.0
// ============================================================================
module angle_accum
    import render_pkg::*;
#(
    parameter angle_t ANGLE_STEP = ANGLE_STEP_DEF,
    parameter angle_t ANGLE_MAX  = ANGLE_MAX_DEF
) (
    input  logic   Clk,
    input  logic   Reset,
    input  logic   advance,
    output angle_t theta
);

    angle_t theta_q;
    angle_t theta_d;

    // The wrap test uses the current value, so theta may briefly exceed ANGLE_MAX.
    always_comb begin
        theta_d = theta_q;
        if (advance) begin
            theta_d = (theta_q >= ANGLE_MAX) ? '0 : theta_q + ANGLE_STEP;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            theta_q <= '0;
        end else begin
            theta_q <= theta_d;
        end
    end

    assign theta = theta_q;

endmodule
`default_nettype wire

// File: rtl/render_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : render_sequencer
// Purpose  : Per-frame trig / vertex issue / drain / draw scheduler.
//            Optional macro OVERRUN_CNT_EN adds a saturating overrun_cnt port.
// Revision : 1.0
// ============================================================================
module render_sequencer
    import render_pkg::*;
#(
    parameter int unsigned NUM_VERTS  = 8,
    parameter angle_t      ANGLE_STEP = ANGLE_STEP_DEF,
    parameter angle_t      ANGLE_MAX  = ANGLE_MAX_DEF
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              frame_clk_rising_edge,
    output angle_t                            theta,
    output logic                              trig_req,
    input  logic                              trig_ack,
    output logic                              xf_valid,
    input  logic                              xf_ready,
    output logic [idx_width(NUM_VERTS)-1:0]   xf_vidx,
    input  logic                              xf_done,
    input  logic                              draw_busy,
    output logic                              draw_start,
    output logic                              busy,
    output logic                              overrun
`ifdef OVERRUN_CNT_EN
    ,
    output logic [7:0]                        overrun_cnt
`endif
);

    localparam int VW = idx_width(NUM_VERTS);
    localparam int CW = $clog2(NUM_VERTS + 1);
    localparam logic [VW-1:0] C_LAST_IDX    = VW'(NUM_VERTS - 1);
    localparam logic [CW-1:0] C_DONE_FULL   = CW'(NUM_VERTS);
    localparam logic [CW-1:0] C_DONE_PENULT = CW'(NUM_VERTS - 1);

    seq_state_t    state_q;
    logic [VW-1:0] vidx_q;
    logic [CW-1:0] done_cnt_q;
    logic          trig_req_q;
    logic          xf_valid_q;
    logic          draw_start_q;
    logic          overrun_q;

    logic w_advance;
    logic w_tick_drop;
    logic w_done_count;
    logic w_drain_exit;

    assign w_advance    = frame_clk_rising_edge && (state_q == IDLE);
    assign w_tick_drop  = frame_clk_rising_edge && (state_q != IDLE);
    assign w_done_count = xf_done && ((state_q == ISSUE) || (state_q == DRAIN));
    // A result landing in the exit cycle itself completes the frame.
    assign w_drain_exit = (done_cnt_q == C_DONE_FULL) ||
                          ((done_cnt_q == C_DONE_PENULT) && xf_done);

    angle_accum #(
        .ANGLE_STEP (ANGLE_STEP),
        .ANGLE_MAX  (ANGLE_MAX)
    ) u_angle (
        .Clk     (Clk),
        .Reset   (Reset),
        .advance (w_advance),
        .theta   (theta)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            vidx_q       <= '0;
            done_cnt_q   <= '0;
            trig_req_q   <= 1'b0;
            xf_valid_q   <= 1'b0;
            draw_start_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= w_tick_drop;
            if (w_done_count && (done_cnt_q != C_DONE_FULL)) begin
                done_cnt_q <= done_cnt_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (frame_clk_rising_edge) begin
                        state_q    <= TRIG;
                        trig_req_q <= 1'b1;
                        vidx_q     <= '0;
                        done_cnt_q <= '0;
                    end
                end
                TRIG: begin
                    if (trig_ack) begin
                        state_q    <= ISSUE;
                        trig_req_q <= 1'b0;
                        xf_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (xf_ready) begin
                        if (vidx_q == C_LAST_IDX) begin
                            state_q    <= DRAIN;
                            xf_valid_q <= 1'b0;
                        end else begin
                            vidx_q <= vidx_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drain_exit) begin
                        state_q      <= DRAW;
                        draw_start_q <= !draw_busy;
                    end
                end
                DRAW: begin
                    // The kick is registered, so leave one cycle after it is raised.
                    if (draw_start_q) begin
                        state_q      <= IDLE;
                        draw_start_q <= 1'b0;
                    end else if (!draw_busy) begin
                        draw_start_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    trig_req_q   <= 1'b0;
                    xf_valid_q   <= 1'b0;
                    draw_start_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            overrun_cnt_q <= '0;
        end else if (w_tick_drop && (overrun_cnt_q != 8'hff)) begin
            overrun_cnt_q <= overrun_cnt_q + 8'd1;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
`endif

    assign trig_req   = trig_req_q;
    assign xf_valid   = xf_valid_q;
    assign xf_vidx    = vidx_q;
    assign draw_start = draw_start_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_render_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_render_sequencer
// Purpose  : Self-checking bench: frame vector table, random frames, wrap,
//            overrun and mid-frame reset sequences against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_render_sequencer;

    localparam int          NV     = 8;
    localparam int          STEP   = 26;    // 12'h01a
    localparam int          AMAX   = 1608;  // 12'h648
    // Frames until theta first reaches or passes AMAX, plus the wrap frame.
    localparam int          PERIOD = (AMAX + STEP - 1) / STEP + 1;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        tick;
    logic        trig_ack;
    logic        xf_ready;
    logic        xf_done;
    logic        draw_busy;
    logic [11:0] theta;
    logic        trig_req;
    logic        xf_valid;
    logic [2:0]  xf_vidx;
    logic        draw_start;
    logic        busy;
    logic        overrun;
`ifdef OVERRUN_CNT_EN
    logic [7:0]  overrun_cnt;
`endif

    int n_pass = 0;
    int n_chk  = 0;
    int frames = 0;
    int ovr_total = 0;

    always #5 Clk = ~Clk;

    render_sequencer #(
        .NUM_VERTS  (NV),
        .ANGLE_STEP (12'h01a),
        .ANGLE_MAX  (12'h648)
    ) dut (
        .Clk                   (Clk),
        .Reset                 (Reset),
        .frame_clk_rising_edge (tick),
        .theta                 (theta),
        .trig_req              (trig_req),
        .trig_ack              (trig_ack),
        .xf_valid              (xf_valid),
        .xf_ready              (xf_ready),
        .xf_vidx               (xf_vidx),
        .xf_done               (xf_done),
        .draw_busy             (draw_busy),
        .draw_start            (draw_start),
        .busy                  (busy),
        .overrun               (overrun)
`ifdef OVERRUN_CNT_EN
        ,
        .overrun_cnt           (overrun_cnt)
`endif
    );

    typedef struct {
        int          ack_dly;
        int          rdy_mode;   // 0 always ready, 1 toggle, 2 random
        int          done_lat;
        int          busy_hold;
        int          tick_mode;  // 0 none, 1 tick in DRAIN, 2 tick on draw_start
        logic [11:0] exp_theta;
        int          exp_ovr;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Angle after n accepted frames since reset, from the frame count alone.
    function automatic int model_theta(input int n);
        return (n % PERIOD) * STEP;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_theta"},      32'(theta),      0);
        chk({nm, "_trig_req"},   32'(trig_req),   0);
        chk({nm, "_xf_valid"},   32'(xf_valid),   0);
        chk({nm, "_xf_vidx"},    32'(xf_vidx),    0);
        chk({nm, "_draw_start"}, 32'(draw_start), 0);
        chk({nm, "_busy"},       32'(busy),       0);
        chk({nm, "_overrun"},    32'(overrun),    0);
`ifdef OVERRUN_CNT_EN
        chk({nm, "_overrun_cnt"}, 32'(overrun_cnt), 0);
`endif
    endtask

    task automatic run_frame(input int ack_dly, input int rdy_mode, input int done_lat,
                             input int busy_hold, input int tick_mode,
                             input int exp_theta, input int exp_ovr);
        int   cyc = 0;
        int   t_req = -1, t_ack = -1, t_valid = -1, t_last_hs = -1, t_last_done = -1;
        int   t_dbl = -1, t_start = -1, t_idle = -1, t_inj = -1, t_ovr = -1, theta1 = -1;
        int   hs = 0, starts = 0, ovr = 0, n_done = 0, hold_err = 0, order_err = 0;
        int   due[$];
        bit   stalled = 1'b0, timed_out = 1'b0, fin = 1'b0;
        logic [2:0] prev_vidx = '0;
        logic rdy, dbusy, tk, ack, dn;
        while (!fin) begin
            if (cyc == 1) theta1 = int'(theta);
            if (trig_req && t_req < 0) t_req = cyc;
            if (xf_valid && t_valid < 0) t_valid = cyc;
            if (overrun) begin
                ovr++;
                if (t_ovr < 0) t_ovr = cyc;
            end
            if (draw_start) begin
                starts++;
                if (t_start < 0) t_start = cyc;
            end
            if (stalled && xf_valid && (xf_vidx != prev_vidx)) hold_err++;
            if (t_start >= 0 && !busy) begin
                t_idle = cyc;
                fin = 1'b1;
            end else if (cyc >= 400) begin
                timed_out = 1'b1;
                fin = 1'b1;
            end
            if (!fin) begin
                tk = (cyc == 0) ||
                     (tick_mode == 1 && hs == NV && cyc == t_last_hs + 1) ||
                     (tick_mode == 2 && draw_start && cyc == t_start);
                if (tk && cyc != 0) t_inj = cyc;
                ack = (t_req >= 0 && cyc == t_req + ack_dly);
                if (ack) t_ack = cyc;
                else if (rdy_mode == 2 && t_ack >= 0) ack = ($urandom_range(0, 3) == 0);
                case (rdy_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cyc % 2 == 0);
                    default: rdy = ($urandom_range(0, 1) == 1);
                endcase
                if (xf_valid && rdy) begin
                    if (int'(xf_vidx) != hs) order_err++;
                    hs++;
                    due.push_back(cyc + done_lat);
                    t_last_hs = cyc;
                end
                stalled   = xf_valid && !rdy;
                prev_vidx = xf_vidx;
                dn = (due.size() > 0 && due[0] == cyc);
                if (dn) begin
                    void'(due.pop_front());
                    n_done++;
                    if (n_done == NV) t_last_done = cyc;
                end
                dbusy = (busy_hold > 0) && (t_last_done < 0 || cyc <= t_last_done + busy_hold);
                if (t_last_done >= 0 && t_dbl < 0 && !dbusy) t_dbl = cyc;
                tick      = tk;
                trig_ack  = ack;
                xf_ready  = rdy;
                xf_done   = dn;
                draw_busy = dbusy;
                step();
                cyc++;
            end
        end
        tick = 1'b0; trig_ack = 1'b0; xf_ready = 1'b0; xf_done = 1'b0; draw_busy = 1'b0;

        chk("frame_timeout",     32'(timed_out), 0);
        chk("trig_rise_cycle",   t_req,     1);
        chk("theta_on_tick",     theta1,    exp_theta);
        chk("valid_after_ack",   t_valid,   t_ack + 1);
        chk("handshakes",        hs,        NV);
        chk("issue_order_errs",  order_err, 0);
        chk("stall_hold_errs",   hold_err,  0);
        chk("draw_start_pulses", starts,    1);
        chk("draw_start_cycle",  t_start,   t_dbl + 1);
        chk("busy_fall_cycle",   t_idle,    t_start + 1);
        chk("overrun_pulses",    ovr,       exp_ovr);
        if (exp_ovr > 0) chk("overrun_cycle", t_ovr, t_inj + 1);
        chk("theta_held",        32'(theta), exp_theta);
`ifdef OVERRUN_CNT_EN
        ovr_total += exp_ovr;
        chk("overrun_cnt",       32'(overrun_cnt), ovr_total);
`endif
        step();
        chk("idle_after_frame",  32'(busy), 0);
    endtask

    task automatic reset_mid_frame();
        int cyc = 0;
        int t_req = -1;
        bit hit = 1'b0;
        int due[$];
        while (!hit && cyc < 100) begin
            if (trig_req && t_req < 0) t_req = cyc;
            if (xf_valid && xf_vidx == 3'd3) hit = 1'b1;
            tick     = (cyc == 0);
            trig_ack = (t_req >= 0 && cyc == t_req + 1);
            xf_ready = 1'b1;
            if (xf_valid) due.push_back(cyc + 3);
            xf_done = (due.size() > 0 && due[0] == cyc);
            if (xf_done) void'(due.pop_front());
            Reset = hit;
            step();
            cyc++;
        end
        chk("reset_reached_issue", 32'(hit), 1);
        Reset = 1'b0; tick = 1'b0; trig_ack = 1'b0; xf_ready = 1'b0;
        check_reset_outputs("mid_reset");
        // Results from the aborted frame still trickle back.
        repeat (3) begin
            xf_done = 1'b1;
            step();
        end
        xf_done = 1'b0;
        chk("late_done_busy",  32'(busy),     0);
        chk("late_done_valid", 32'(xf_valid), 0);
        frames    = 0;
        ovr_total = 0;
        frames++;
        run_frame(1, 0, 3, 0, 0, model_theta(frames), 0);
    endtask

    initial begin
        int ack_dly, rdy_mode, lat, hold, tm;
        Reset = 1'b1; tick = 1'b0; trig_ack = 1'b0; xf_ready = 1'b0;
        xf_done = 1'b0; draw_busy = 1'b0;
        repeat (3) step();
        check_reset_outputs("por");
        Reset = 1'b0;
        step();

        vecs[0] = '{2, 0, 3,  0, 0, 12'h01a, 0};
        vecs[1] = '{0, 1, 3,  0, 0, 12'h034, 0};
        vecs[2] = '{1, 0, 3, 10, 0, 12'h04e, 0};
        vecs[3] = '{2, 0, 3,  0, 1, 12'h068, 1};
        vecs[4] = '{1, 0, 1,  0, 2, 12'h082, 1};
        vecs[5] = '{3, 2, 5,  3, 0, 12'h09c, 0};
        for (int i = 0; i < 6; i++) begin
            frames++;
            run_frame(vecs[i].ack_dly, vecs[i].rdy_mode, vecs[i].done_lat,
                      vecs[i].busy_hold, vecs[i].tick_mode,
                      int'(vecs[i].exp_theta), vecs[i].exp_ovr);
        end

        for (int i = 0; i < 20; i++) begin
            ack_dly  = int'($urandom_range(0, 4));
            rdy_mode = int'($urandom_range(0, 2));
            lat      = int'($urandom_range(1, 6));
            hold     = int'($urandom_range(0, 4));
            tm       = int'($urandom_range(0, 2));
            frames++;
            run_frame(ack_dly, rdy_mode, lat, hold, tm, model_theta(frames), (tm != 0) ? 1 : 0);
        end

        while (frames < PERIOD) begin
            frames++;
            run_frame(0, 0, 1, 0, 0, model_theta(frames), 0);
        end
        chk("wrap_to_zero", 32'(theta), 0);

        reset_mid_frame();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
